// File: rtl/fp_dec_pkg.sv
// Shared types and constants for the float-to-BCD display converter.
// Combinational only; no latency.
// No flow control; definitions only.
package fp_dec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    INT_CONV,
    FRAC_CONV,
    DONE
  } fp_dec_state_t;

  localparam int         EXP_BIAS    = 127;
  localparam logic [7:0] EXP_SPECIAL = 8'hFF;
  localparam int         MANT_W      = 24;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_add3_shift.sv
// One double-dabble step: add 3 to every digit >= 5, then shift one bit in at the LSB.
// Purely combinational, zero latency.
// No flow control; caller decides when to register the result.
module bcd_add3_shift #(
  parameter int DIGITS = 9
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] bcd_out
);

  logic [4*DIGITS-5:0] low_adj;
  logic [3:0]          top_dig;
  logic [2:0]          top_adj;

  assign top_dig = bcd_in[4*DIGITS-1 -: 4];

  // add-3 correction on every digit below the most significant one
  always_comb begin
    low_adj = bcd_in[4*DIGITS-5:0];
    for (int d = 0; d < DIGITS-1; d++) begin
      if (bcd_in[4*d +: 4] >= 4'd5) begin
        low_adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
      end
    end
  end

  // the MS digit's top bit falls off the shift, so only its low three bits survive
  assign top_adj = (top_dig >= 4'd5) ? (top_dig[2:0] + 3'd3) : top_dig[2:0];

  assign bcd_out = {top_adj, low_adj, bit_in};

endmodule

// File: rtl/fp_to_bcd_seq.sv
// Converts one IEEE754 single (plus add_sub ovf/unf) to sign, integer BCD and truncated fraction BCD.
// Latency from accept: result in cycle 2+INT_BITS+FRAC_DIGITS, or cycle 2 for special/flagged inputs.
// One conversion in flight; in_ready only in IDLE, result held with out_valid until out_ready.
module fp_to_bcd_seq
  import fp_dec_pkg::*;
#(
  parameter int INT_BITS    = 27,
  parameter int INT_DIGITS  = 9,
  parameter int FRAC_BITS   = 32,
  parameter int FRAC_DIGITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              fp_in,
  input  logic                     in_ovf,
  input  logic                     in_unf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sign,
  output logic [4*INT_DIGITS-1:0]  int_bcd,
  output logic [4*FRAC_DIGITS-1:0] frac_bcd,
  output logic                     is_zero,
  output logic                     is_inf,
  output logic                     is_nan,
  output logic                     too_big
);

  localparam int W     = INT_BITS + FRAC_BITS;
  localparam int ID_W  = 4 * INT_DIGITS;
  localparam int FD_W  = 4 * FRAC_DIGITS;
  localparam int CNT_W = $clog2(max_int(INT_BITS, FRAC_DIGITS) + 1);

  localparam logic [7:0]       BIAS8     = 8'(EXP_BIAS);
  localparam logic [7:0]       EXP_BIG   = 8'(EXP_BIAS + INT_BITS);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INT_BITS - 1);
  localparam logic [CNT_W-1:0] FRAC_LAST = CNT_W'(FRAC_DIGITS - 1);

  fp_dec_state_t state;

  logic [31:0]          fp_r;
  logic                 ovf_r;
  logic                 unf_r;
  logic [INT_BITS-1:0]  int_r;
  logic [FRAC_BITS-1:0] frac_r;
  logic [ID_W-1:0]      bcd_acc;
  logic [ID_W-1:0]      bcd_next;
  logic [FD_W-1:0]      frac_acc;
  logic [CNT_W-1:0]     cnt;

  logic [7:0]           exp_f;
  logic [22:0]          man_f;
  logic                 sh_left;
  logic [7:0]           sh_amt;
  logic [W-1:0]         base;
  logic [W-1:0]         aligned;
  logic                 f_nan;
  logic                 f_inf;
  logic                 f_big;
  logic                 f_zero;
  logic                 any_flag;
  logic [FRAC_BITS+3:0] prod;
  logic [3:0]           digit;

  assign exp_f = fp_r[30:23];
  assign man_f = fp_r[22:0];

  // hidden bit lands at the binary point, which sits between int and fraction fields
  assign base    = {{(W-MANT_W){1'b0}}, 1'b1, man_f} << (FRAC_BITS - (MANT_W - 1));
  assign sh_left = (exp_f >= BIAS8);
  assign sh_amt  = sh_left ? (exp_f - BIAS8) : (BIAS8 - exp_f);
  // right shifts past the word width simply clear it, which handles tiny values
  assign aligned = sh_left ? (base << sh_amt) : (base >> sh_amt);

  // flags are mutually exclusive, highest priority first
  assign f_nan    = (exp_f == EXP_SPECIAL) && (man_f != 23'd0);
  assign f_inf    = (exp_f == EXP_SPECIAL) && (man_f == 23'd0);
  assign f_big    = !f_nan && !f_inf && (ovf_r || (exp_f >= EXP_BIG));
  assign f_zero   = !f_nan && !f_inf && !f_big && ((exp_f == 8'd0) || unf_r);
  assign any_flag = f_nan || f_inf || f_big || f_zero;

  // x10 as x8 + x2; the carry nibble is the next decimal digit
  assign prod  = {1'b0, frac_r, 3'b000} + {3'b000, frac_r, 1'b0};
  assign digit = prod[FRAC_BITS+3:FRAC_BITS];

  bcd_add3_shift #(
    .DIGITS (INT_DIGITS)
  ) u_add3 (
    .bcd_in  (bcd_acc),
    .bit_in  (int_r[INT_BITS-1]),
    .bcd_out (bcd_next)
  );

  // conversion FSM; output registers load only on the transition into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      fp_r      <= '0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      int_r     <= '0;
      frac_r    <= '0;
      bcd_acc   <= '0;
      frac_acc  <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      int_bcd   <= '0;
      frac_bcd  <= '0;
      is_zero   <= 1'b0;
      is_inf    <= 1'b0;
      is_nan    <= 1'b0;
      too_big   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            fp_r     <= fp_in;
            ovf_r    <= in_ovf;
            unf_r    <= in_unf;
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          if (any_flag) begin
            sign      <= f_zero ? 1'b0 : fp_r[31];
            int_bcd   <= '0;
            frac_bcd  <= '0;
            is_nan    <= f_nan;
            is_inf    <= f_inf;
            too_big   <= f_big;
            is_zero   <= f_zero;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            int_r    <= aligned[W-1:FRAC_BITS];
            frac_r   <= aligned[FRAC_BITS-1:0];
            bcd_acc  <= '0;
            frac_acc <= '0;
            cnt      <= '0;
            state    <= INT_CONV;
          end
        end
        INT_CONV: begin
          bcd_acc <= bcd_next;
          int_r   <= int_r << 1;
          if (cnt == INT_LAST) begin
            cnt   <= '0;
            state <= FRAC_CONV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FRAC_CONV: begin
          frac_r   <= prod[FRAC_BITS-1:0];
          frac_acc <= {frac_acc[FD_W-5:0], digit};
          if (cnt == FRAC_LAST) begin
            sign      <= fp_r[31];
            int_bcd   <= bcd_acc;
            frac_bcd  <= {frac_acc[FD_W-5:0], digit};
            is_nan    <= 1'b0;
            is_inf    <= 1'b0;
            too_big   <= 1'b0;
            is_zero   <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_bcd_seq.sv
// Self-checking bench for fp_to_bcd_seq: vector table, random inputs vs a real-arithmetic model,
// plus hand sequences for back-pressure and mid-conversion reset.
// Inputs driven and outputs sampled on the falling edge.
module tb_fp_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        in_ovf;
  logic        in_unf;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [35:0] int_bcd;
  logic [23:0] frac_bcd;
  logic        is_zero;
  logic        is_inf;
  logic        is_nan;
  logic        too_big;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_to_bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .in_ovf    (in_ovf),
    .in_unf    (in_unf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .int_bcd   (int_bcd),
    .frac_bcd  (frac_bcd),
    .is_zero   (is_zero),
    .is_inf    (is_inf),
    .is_nan    (is_nan),
    .too_big   (too_big)
  );

  // flags packed as {nan, inf, too_big, zero}
  typedef struct {
    string       nm;
    logic [31:0] f;
    logic        ov;
    logic        un;
    logic        sg;
    logic [35:0] ib;
    logic [23:0] fb;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  logic [64:0] dut_out;
  assign dut_out = {sign, is_nan, is_inf, too_big, is_zero, int_bcd, frac_bcd};

  function automatic logic [64:0] pack_exp(input vec_t v);
    return {v.sg, v.fl, v.ib, v.fb};
  endfunction

  task automatic chk(input string nm, input logic [66:0] got, input logic [66:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic add(input string nm, input logic [31:0] f, input logic ov, input logic un,
                     input logic sg, input logic [35:0] ib, input logic [23:0] fb,
                     input logic [3:0] fl, input int lat);
    vec_t v;
    v.nm = nm; v.f = f; v.ov = ov; v.un = un; v.sg = sg;
    v.ib = ib; v.fb = fb; v.fl = fl; v.lat = lat;
    vecs.push_back(v);
  endtask

  function automatic logic [35:0] to_bcd(input longint val);
    logic [35:0] b;
    longint t;
    b = '0;
    t = val;
    for (int i = 0; i < 9; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // reference: classify, then take the exact value and truncate it arithmetically
  function automatic vec_t model(input logic [31:0] f, input logic ov, input logic un);
    vec_t   r;
    int     e;
    real    mag;
    longint ip;
    longint fbits;
    longint fd;
    logic [35:0] tmp;
    r.nm = "rand"; r.f = f; r.ov = ov; r.un = un;
    r.ib = '0; r.fb = '0; r.fl = 4'b0000;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF && f[22:0] != 23'd0) r.fl = 4'b1000;
    else if (f[30:23] == 8'hFF)                r.fl = 4'b0100;
    else if (ov || e >= 27)                    r.fl = 4'b0010;
    else if (f[30:23] == 8'd0 || un)           r.fl = 4'b0001;
    r.lat = (r.fl != 4'b0000) ? 2 : 35;
    r.sg  = (r.fl == 4'b0001) ? 1'b0 : f[31];
    if (r.fl == 4'b0000) begin
      mag   = real'({1'b1, f[22:0]}) * (2.0 ** (e - 23));
      ip    = longint'($floor(mag));
      fbits = longint'($floor((mag - real'(ip)) * 4294967296.0));
      fd    = (fbits * 1000000) >> 32;
      r.ib  = to_bcd(ip);
      tmp   = to_bcd(fd);
      r.fb  = tmp[23:0];
    end
    return r;
  endfunction

  task automatic start(input logic [31:0] f, input logic ov, input logic un, input string nm);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk({nm, " in_ready"}, 67'(in_ready), 67'd1);
    fp_in = f; in_ovf = ov; in_unf = un; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    fp_in = $urandom; in_ovf = 1'b0; in_unf = 1'b0;
  endtask

  // called in cycle 1 after accept; returns the cycle at which out_valid is first seen
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_conv(input vec_t v);
    int cyc;
    start(v.f, v.ov, v.un, v.nm);
    wait_valid(cyc);
    chk({v.nm, " latency"}, 67'(cyc), 67'(v.lat));
    chk({v.nm, " result"}, 67'(dut_out), 67'(pack_exp(v)));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    logic        ov;
    logic        un;
    int          cyc;
    int          seen;
    vec_t        one;

    add("one",      32'h3F800000, 0, 0, 0, 36'h000000001, 24'h000000, 4'b0000, 35);
    add("m12.375",  32'hC1460000, 0, 0, 1, 36'h000000012, 24'h375000, 4'b0000, 35);
    add("pt1",      32'h3DCCCCCD, 0, 0, 0, 36'h000000000, 24'h100000, 4'b0000, 35);
    add("half",     32'h3F000000, 0, 0, 0, 36'h000000000, 24'h500000, 4'b0000, 35);
    add("just2",    32'h3FFFFFFF, 0, 0, 0, 36'h000000001, 24'h999999, 4'b0000, 35);
    add("999",      32'h4479C000, 0, 0, 0, 36'h000000999, 24'h000000, 4'b0000, 35);
    add("maxint",   32'h4CFFFFFF, 0, 0, 0, 36'h134217720, 24'h000000, 4'b0000, 35);
    add("tiny_neg", 32'hAF000000, 0, 0, 1, 36'h000000000, 24'h000000, 4'b0000, 35);
    add("e_minus32",32'h2F800000, 0, 0, 0, 36'h000000000, 24'h000000, 4'b0000, 35);
    add("inf",      32'h7F800000, 0, 0, 0, 36'h0, 24'h0, 4'b0100, 2);
    add("neg_inf",  32'hFF800000, 0, 0, 1, 36'h0, 24'h0, 4'b0100, 2);
    add("nan",      32'h7FC00000, 0, 0, 0, 36'h0, 24'h0, 4'b1000, 2);
    add("1e9",      32'h4E6E6B28, 0, 0, 0, 36'h0, 24'h0, 4'b0010, 2);
    add("e27",      32'h4D000000, 0, 0, 0, 36'h0, 24'h0, 4'b0010, 2);
    add("ovf",      32'h3F800000, 1, 0, 0, 36'h0, 24'h0, 4'b0010, 2);
    add("unf",      32'hC1460000, 0, 1, 0, 36'h0, 24'h0, 4'b0001, 2);
    add("neg_zero", 32'h80000000, 0, 0, 0, 36'h0, 24'h0, 4'b0001, 2);
    add("denorm",   32'h00000001, 0, 0, 0, 36'h0, 24'h0, 4'b0001, 2);
    add("nan_prio", 32'h7FC00000, 1, 1, 0, 36'h0, 24'h0, 4'b1000, 2);
    add("inf_prio", 32'h7F800000, 1, 0, 0, 36'h0, 24'h0, 4'b0100, 2);
    add("big_prio", 32'hBF800000, 1, 1, 1, 36'h0, 24'h0, 4'b0010, 2);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fp_in = '0; in_ovf = 1'b0; in_unf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset state", {in_ready, out_valid, dut_out}, {1'b1, 1'b0, 65'd0});

    foreach (vecs[i]) run_conv(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      f = $urandom;
      case ($urandom_range(0, 9))
        0:       f[30:23] = 8'hFF;
        1:       f[30:23] = 8'h00;
        default: f[30:23] = 8'($urandom_range(90, 160));
      endcase
      ov = ($urandom_range(0, 15) == 0);
      un = ($urandom_range(0, 15) == 0);
      run_conv(model(f, ov, un));
    end

    // back-pressure: result must hold in DONE; in_valid during busy/DONE is ignored
    one = vecs[0];
    out_ready = 1'b0;
    start(one.f, 1'b0, 1'b0, "bp");
    wait_valid(cyc);
    chk("bp latency", 67'(cyc), 67'd35);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      fp_in = 32'h4479C000;
      @(negedge clk);
      chk("bp hold", {out_valid, in_ready, dut_out}, {1'b1, 1'b0, pack_exp(one)});
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp release", {out_valid, in_ready, dut_out}, {1'b0, 1'b1, pack_exp(one)});
    @(negedge clk);
    chk("bp no accept", {out_valid, in_ready}, 67'b01);

    // reset during INT_CONV aborts the conversion and clears held outputs
    start(32'hC1460000, 1'b0, 1'b0, "rst_mid");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid state", {in_ready, out_valid, dut_out}, {1'b1, 1'b0, 65'd0});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mid no out_valid", 67'(seen), 67'd0);
    run_conv(vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
